// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
//
// Write-back and hazard stage in front of the 8-entry register file. It merges
// single-cycle ALU results with fixed-latency data-memory load returns into
// one registered register-file write port, keeps a one-entry skid for an ALU
// result that collides with a load return, and tracks in-flight loads with a
// per-register pending scoreboard so decode can be stalled on hazards.
//
// Parameters:
//   W         data path width
//   LOAD_LAT  data-memory read latency in cycles (legal range 1..4)
//
// Ports:
//   Clk                 clock, all state updates on the rising edge
//   Reset_n             synchronous active-low reset
//   AluValid/Dest/Data  ALU result for this cycle
//   LoadIssue/LoadDest  load issued to data memory this cycle
//   MemData             load data, valid LOAD_LAT cycles after issue
//   RdEnA/B, RaddrA/B   decode source operand usage and addresses
//   Stall               combinational; decode must hold its instruction
//   RfWe/RfWaddr/RfWdata registered register-file write port
//   FwdValidA/B, FwdDataA/B  bypass from the write-port register
//
// Configuration macro:
//   REG_WRITEBACK_FORWARD_EN  when defined, a source that matches the
//   current write-port register is bypassed instead of stalled. When
//   undefined, the bypass outputs are tied to zero and such a match stalls
//   decode for that one cycle.
// ---------------------------------------------------------------------------
module reg_writeback #(
    parameter int W        = 8,
    parameter int LOAD_LAT = 2
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         AluValid,
    input  logic [2:0]   AluDest,
    input  logic [W-1:0] AluData,
    input  logic         LoadIssue,
    input  logic [2:0]   LoadDest,
    input  logic [W-1:0] MemData,
    input  logic         RdEnA,
    input  logic         RdEnB,
    input  logic [2:0]   RaddrA,
    input  logic [2:0]   RaddrB,
    output logic         Stall,
    output logic         RfWe,
    output logic [2:0]   RfWaddr,
    output logic [W-1:0] RfWdata,
    output logic         FwdValidA,
    output logic         FwdValidB,
    output logic [W-1:0] FwdDataA,
    output logic [W-1:0] FwdDataB
);

    // Load tracker: one {valid, dest} slot per cycle of memory latency.
    logic [LOAD_LAT-1:0] LdValid;
    logic [2:0]          LdDest [LOAD_LAT];

    // Registers whose load result has not yet reached the write-port register.
    logic [7:0] Pending;

    // One-entry skid for an ALU result displaced by a load return.
    logic         SkidValid;
    logic [2:0]   SkidDest;
    logic [W-1:0] SkidData;

    logic       LoadReturn;
    logic [2:0] ReturnDest;
    logic       AluAccept;
    logic       LoadAccept;
    logic       HazardA;
    logic       HazardB;
    logic [7:0] PendingSet;
    logic [7:0] PendingClear;

    assign LoadReturn = LdValid[LOAD_LAT-1];
    assign ReturnDest = LdDest[LOAD_LAT-1];

    // Upstream holds its request while stalled, so nothing is taken then.
    assign AluAccept  = AluValid  && !Stall;
    assign LoadAccept = LoadIssue && !Stall;

    // Per-source hazard detection. A source is not readable while a load to
    // it is in flight, while the skid holds a result for it, and (without
    // bypassing) during the cycle its write is sitting in the output
    // register, because the register file still returns the old value then.
    always_comb begin
        HazardA = RdEnA && (Pending[RaddrA] || (SkidValid && (SkidDest == RaddrA)));
        HazardB = RdEnB && (Pending[RaddrB] || (SkidValid && (SkidDest == RaddrB)));
`ifndef REG_WRITEBACK_FORWARD_EN
        if (RdEnA && RfWe && (RfWaddr == RaddrA)) begin
            HazardA = 1'b1;
        end
        if (RdEnB && RfWe && (RfWaddr == RaddrB)) begin
            HazardB = 1'b1;
        end
`endif
    end

    // A full skid always stalls so the skid can never be overwritten. A new
    // load to a register that already has one in flight is held back so the
    // two returns can never be reordered against the scoreboard.
    assign Stall = SkidValid || HazardA || HazardB ||
                   (LoadIssue && Pending[LoadDest]);

    // Scoreboard update masks. A set and a clear of the same register in one
    // cycle cannot happen: the set needs the issue to be accepted, and the
    // WAW check stalls any issue to a register that is still pending.
    always_comb begin
        PendingSet   = LoadAccept ? (8'(1) << LoadDest)   : 8'd0;
        PendingClear = LoadReturn ? (8'(1) << ReturnDest) : 8'd0;
    end

    // The load pipe shifts every cycle regardless of stall, since the memory
    // returns data at a fixed latency; a stalled cycle just inserts a bubble.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            LdValid <= '0;
            for (int i = 0; i < LOAD_LAT; i++) begin
                LdDest[i] <= '0;
            end
        end else begin
            LdValid[0] <= LoadAccept;
            LdDest[0]  <= LoadDest;
            for (int i = 1; i < LOAD_LAT; i++) begin
                LdValid[i] <= LdValid[i-1];
                LdDest[i]  <= LdDest[i-1];
            end
        end
    end

    // Pending bits are set when a load is accepted and cleared on the edge
    // where its data is captured into the write-port register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Pending <= '0;
        end else begin
            Pending <= (Pending & ~PendingClear) | PendingSet;
        end
    end

    // Write-port selection: a load return always wins because its data only
    // exists for one cycle; a colliding ALU result is parked in the skid and
    // drained next cycle ahead of any new ALU result (which the full skid has
    // already stalled). Address and data hold their last value when idle.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            RfWe      <= 1'b0;
            RfWaddr   <= '0;
            RfWdata   <= '0;
            SkidValid <= 1'b0;
            SkidDest  <= '0;
            SkidData  <= '0;
        end else if (LoadReturn) begin
            RfWe    <= 1'b1;
            RfWaddr <= ReturnDest;
            RfWdata <= MemData;
            if (AluAccept) begin
                SkidValid <= 1'b1;
                SkidDest  <= AluDest;
                SkidData  <= AluData;
            end
        end else if (SkidValid) begin
            RfWe      <= 1'b1;
            RfWaddr   <= SkidDest;
            RfWdata   <= SkidData;
            SkidValid <= 1'b0;
        end else if (AluAccept) begin
            RfWe    <= 1'b1;
            RfWaddr <= AluDest;
            RfWdata <= AluData;
        end else begin
            RfWe <= 1'b0;
        end
    end

    // Bypass from the write-port register covers the one cycle in which the
    // register file would still return stale data.
`ifdef REG_WRITEBACK_FORWARD_EN
    assign FwdValidA = RdEnA && RfWe && (RfWaddr == RaddrA);
    assign FwdValidB = RdEnB && RfWe && (RfWaddr == RaddrB);
    assign FwdDataA  = RfWdata;
    assign FwdDataB  = RfWdata;
`else
    assign FwdValidA = 1'b0;
    assign FwdValidB = 1'b0;
    assign FwdDataA  = '0;
    assign FwdDataB  = '0;
`endif

endmodule
